// File: rtl/vga_compositor.sv
`default_nettype none
// vga_compositor: VGA raster timing with priority-keyed layer compositing and pipeline-aligned syncs.
// Optional colour-bar test pattern is compiled in with VGA_COMPOSITOR_TESTPAT_EN.
module vga_compositor #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          PCLK_DIV   = 4,
  parameter int          N_LAYERS   = 3,
  parameter int          SRC_LAT    = 1,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_LAYERS-1:0]    layer_en,
  input  logic [12*N_LAYERS-1:0] layer_pixel,
  input  logic                   force_black,
`ifdef VGA_COMPOSITOR_TESTPAT_EN
  input  logic                   testpat_sel,
`endif
  output logic [9:0]             h_cnt,
  output logic [9:0]             v_cnt,
  output logic                   pix_tick,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   valid,
  output logic [3:0]             vga_red,
  output logic [3:0]             vga_green,
  output logic [3:0]             vga_blue
);

  localparam int         H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int         DEPTH     = SRC_LAT + 1;
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] TICK_LAST = 4'(PCLK_DIV - 1);

  logic [3:0] tick_cnt;
  logic [3:0] tick_nxt;

  always_comb tick_nxt = (tick_cnt == TICK_LAST) ? 4'd0 : tick_cnt + 4'd1;

  // Strobe is registered from the next count so it is high exactly while tick_cnt == TICK_LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      pix_tick <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      pix_tick <= (tick_nxt == TICK_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign frame_start = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  logic raw_hsync;
  logic raw_vsync;
  logic raw_valid;

  assign raw_hsync = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign raw_vsync = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign raw_valid = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  logic [DEPTH-1:0] hs_pipe;
  logic [DEPTH-1:0] vs_pipe;
  logic [DEPTH-1:0] va_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      va_pipe <= '0;
    end else if (pix_tick) begin
      hs_pipe[0] <= raw_hsync;
      vs_pipe[0] <= raw_vsync;
      va_pipe[0] <= raw_valid;
      for (int i = 1; i < DEPTH; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        va_pipe[i] <= va_pipe[i-1];
      end
    end
  end

  logic [11:0] sel_color;
  logic [11:0] color_q;

  // Walk from lowest priority upward so the lowest qualifying index wins.
  always_comb begin
    sel_color = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i] && (layer_pixel[12*i +: 12] != TRANSP_KEY)) begin
        sel_color = layer_pixel[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q <= '0;
    end else if (pix_tick) begin
      color_q <= sel_color;
    end
  end

`ifdef VGA_COMPOSITOR_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [9:0] bar_full;
  logic [2:0] raw_bar;
  logic [2:0] bar_pipe [DEPTH];

  assign bar_full = h_cnt / 10'(BAR_W);
  assign raw_bar  = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];

  // Bar index rides the sync pipeline so it lines up with the pixel being shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) bar_pipe[i] <= '0;
    end else if (pix_tick) begin
      bar_pipe[0] <= raw_bar;
      for (int i = 1; i < DEPTH; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  function automatic logic [11:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 12'h000;
      3'd1:    bar_rgb = 12'hF00;
      3'd2:    bar_rgb = 12'h0F0;
      3'd3:    bar_rgb = 12'h00F;
      3'd4:    bar_rgb = 12'hFF0;
      3'd5:    bar_rgb = 12'h0FF;
      3'd6:    bar_rgb = 12'hF0F;
      default: bar_rgb = 12'hFFF;
    endcase
  endfunction
`endif

  logic [11:0] out_color;

  always_comb begin
    out_color = color_q;
`ifdef VGA_COMPOSITOR_TESTPAT_EN
    if (testpat_sel) out_color = bar_rgb(bar_pipe[DEPTH-1]);
`endif
    if (!va_pipe[DEPTH-1] || force_black) out_color = 12'h000;
  end

  assign hsync     = hs_pipe[DEPTH-1];
  assign vsync     = vs_pipe[DEPTH-1];
  assign valid     = va_pipe[DEPTH-1];
  assign vga_red   = out_color[11:8];
  assign vga_green = out_color[7:4];
  assign vga_blue  = out_color[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_compositor.sv
`default_nettype none
// tb_vga_compositor: random stimulus against a position-based reference model of the compositor.
// Reduced raster so several frames fit in a short run; honours VGA_COMPOSITOR_TESTPAT_EN.
module tb_vga_compositor;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PD  = 3;
  localparam int NL  = 3;
  localparam int LAT = 2;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam logic [11:0] BG  = 12'h00A;

  logic              clk = 1'b0;
  logic              rst;
  logic [NL-1:0]     layer_en;
  logic [12*NL-1:0]  layer_pixel;
  logic              force_black;
`ifdef VGA_COMPOSITOR_TESTPAT_EN
  logic              testpat_sel;
`endif
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              pix_tick;
  logic              frame_start;
  logic              hsync;
  logic              vsync;
  logic              valid;
  logic [3:0]        vga_red;
  logic [3:0]        vga_green;
  logic [3:0]        vga_blue;

  always #5 clk = ~clk;

  vga_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PCLK_DIV(PD), .N_LAYERS(NL), .SRC_LAT(LAT),
    .TRANSP_KEY(KEY), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_en(layer_en),
    .layer_pixel(layer_pixel),
    .force_black(force_black),
`ifdef VGA_COMPOSITOR_TESTPAT_EN
    .testpat_sel(testpat_sel),
`endif
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .pix_tick(pix_tick),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .valid(valid),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue)
  );

  int checks = 0;
  int errors = 0;

  // Source image per layer, indexed by raster position (v*HT + h).
  logic [11:0]   img [NL][FRAME];
  int            phase;
  int            pos;
  int            ticks;
  logic [NL-1:0] en_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] compose(input int p, input logic [NL-1:0] en);
    for (int i = 0; i < NL; i++) begin
      if (en[i] && img[i][p] != KEY) return img[i][p];
    end
    return BG;
  endfunction

`ifdef VGA_COMPOSITOR_TESTPAT_EN
  function automatic logic [11:0] bar_color(input int h);
    case (h / (HA / 8))
      0:       return 12'h000;
      1:       return 12'hF00;
      2:       return 12'h0F0;
      3:       return 12'h00F;
      4:       return 12'hFF0;
      5:       return 12'h0FF;
      6:       return 12'hF0F;
      default: return 12'hFFF;
    endcase
  endfunction
`endif

  task automatic fill_img(input bit rnd);
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < FRAME; p++) begin
        if (rnd) img[l][p] = ($urandom_range(0, 2) == 0) ? KEY : 12'($urandom);
        else     img[l][p] = (l == 0) ? 12'hF0F : (l == 1) ? 12'h0F0 : 12'hF00;
      end
    end
  endtask

  task automatic model_reset();
    phase   = 0;
    pos     = 0;
    ticks   = 0;
    en_last = '0;
  endtask

  task automatic check_outputs();
    logic        exp_tick;
    logic        eh, ev, eva;
    logic [11:0] ec;
    int          op, oh, ov;
    exp_tick = rst && (phase == PD - 1);
    check("pix_tick", 32'(pix_tick), 32'(exp_tick));
    check("frame_start", 32'(frame_start), 32'(exp_tick && pos == FRAME - 1));
    check("h_cnt", 32'(h_cnt), pos % HT);
    check("v_cnt", 32'(v_cnt), pos / HT);
    eh = 1'b1; ev = 1'b1; eva = 1'b0; ec = 12'h000;
    if (ticks > LAT) begin
      op  = (pos - 1 - LAT + FRAME) % FRAME;
      oh  = op % HT;
      ov  = op / HT;
      eh  = !(oh >= HA + HF && oh < HA + HF + HS);
      ev  = !(ov >= VA + VF && ov < VA + VF + VS);
      eva = (oh < HA) && (ov < VA);
      if (eva && !force_black) begin
        ec = compose(op, en_last);
`ifdef VGA_COMPOSITOR_TESTPAT_EN
        if (testpat_sel) ec = bar_color(oh);
`endif
      end
    end
    check("hsync", 32'(hsync), 32'(eh));
    check("vsync", 32'(vsync), 32'(ev));
    check("valid", 32'(valid), 32'(eva));
    check("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(ec));
  endtask

  // One clock: drive inputs, check just after, then advance the model on the rising edge.
  task automatic cycle(input bit rnd);
    if (rnd) begin
      if ($urandom_range(0, 40) == 0) layer_en = NL'($urandom);
      if ($urandom_range(0, 30) == 0) force_black = ~force_black;
`ifdef VGA_COMPOSITOR_TESTPAT_EN
      if ($urandom_range(0, 200) == 0) testpat_sel = ~testpat_sel;
`endif
    end
    for (int l = 0; l < NL; l++) layer_pixel[12*l +: 12] = img[l][(pos - LAT + FRAME) % FRAME];
    #1;
    check_outputs();
    @(posedge clk);
    if (rst) begin
      if (phase == PD - 1) begin
        pos     = (pos + 1) % FRAME;
        ticks   = ticks + 1;
        en_last = layer_en;
      end
      phase = (phase + 1) % PD;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    layer_en    = '0;
    layer_pixel = '0;
    force_black = 1'b0;
`ifdef VGA_COMPOSITOR_TESTPAT_EN
    testpat_sel = 1'b0;
`endif
    model_reset();
    fill_img(1'b0);
    @(negedge clk);
    repeat (4) cycle(1'b0);
    rst = 1'b1;

    layer_en = 3'b111; repeat (FRAME * PD) cycle(1'b0);
    layer_en = 3'b101; repeat (FRAME * PD / 2) cycle(1'b0);
    layer_en = 3'b000; repeat (FRAME * PD / 2) cycle(1'b0);

    fill_img(1'b1);
    layer_en = '1;
    repeat (3 * FRAME * PD) cycle(1'b1);
    force_black = 1'b0;
    layer_en    = '1;
`ifdef VGA_COMPOSITOR_TESTPAT_EN
    testpat_sel = 1'b1;
    repeat (FRAME * PD) cycle(1'b0);
    testpat_sel = 1'b0;
`endif

    n = 0;
    while (!(pos == 2 * HT + 4 && phase == 0) && n < 2 * FRAME * PD) begin
      cycle(1'b0);
      n++;
    end
    force_black = 1'b1;
    repeat (10 * PD) cycle(1'b0);
    force_black = 1'b0;
    repeat (HT * PD) cycle(1'b0);

    n = 0;
    while (!(pos == 3 * HT + 10 && phase == 1) && n < 2 * FRAME * PD) begin
      cycle(1'b0);
      n++;
    end
    rst = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0);
    rst = 1'b1;
    repeat (2 * FRAME * PD) cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_compositor.md
VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48; H_TOTAL = sum of the four H values.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33; V_TOTAL = sum of the four V values.
REQ-004 SHALL have parameter PCLK_DIV, default 4, clk cycles per pixel tick (range 1..16).
REQ-005 SHALL have parameter N_LAYERS, default 3, overlay channel count (range 1..8); index 0 = highest priority.
REQ-006 SHALL have parameter SRC_LAT, default 1, pixel ticks from h_cnt/v_cnt to valid layer_pixel (range 0..3).
REQ-007 SHALL have parameters TRANSP_KEY, default 12'hF0F (transparent colour), and BG_COLOR, default 12'h000.
REQ-008 clk  in  1  system clock; only clock in the block.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 layer_en  in  N_LAYERS  per-layer enable.
REQ-011 layer_pixel  in  12*N_LAYERS  RGB444 per layer; layer i occupies bits [12i+11:12i].
REQ-012 force_black  in  1  blanks composited output while asserted.
REQ-013 h_cnt, v_cnt  out  10 each  current raster position, for pixel sources.
REQ-014 pix_tick  out  1  one-clk strobe when h_cnt/v_cnt advance.
REQ-015 frame_start  out  1  one-clk strobe coincident with pix_tick when position becomes (0,0).
REQ-016 hsync, vsync  out  1 each  active-low sync, pipeline-aligned.
REQ-017 valid  out  1  active-area flag, pipeline-aligned.
REQ-018 vga_red, vga_green, vga_blue  out  4 each  colour outputs.

Function
REQ-019 Tick counter SHALL count 0..PCLK_DIV-1; pix_tick high when count = PCLK_DIV-1; PCLK_DIV=1 gives pix_tick constantly high.
REQ-020 On pix_tick, h_cnt SHALL increment, wrapping H_TOTAL-1 -> 0; on that wrap, v_cnt SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-021 Raw hsync SHALL be low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync likewise with V values.
REQ-022 Raw valid SHALL be high iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-023 Raw hsync, vsync and valid SHALL pass through a shift register advanced only on pix_tick, depth SRC_LAT+1, so they align with colour outputs.
REQ-024 Compositor SHALL select the lowest index i with layer_en[i]=1 and layer_pixel[i] != TRANSP_KEY; if none qualifies, BG_COLOR.
REQ-025 Selected colour SHALL be registered on pix_tick (one pipeline stage); total latency from h_cnt/v_cnt to colour output = SRC_LAT+1 pixel ticks.
REQ-026 Colour outputs SHALL be 12'h000 when delayed valid = 0 or force_black = 1; force_black SHALL act combinationally on the output without disturbing the pipeline.
REQ-027 All registers SHALL hold between pix_ticks; layer_en changes SHALL take effect at the next pix_tick.
REQ-028 frame_start SHALL pulse exactly once per V_TOTAL*H_TOTAL pixel ticks.

Reset
REQ-029 While rst=0: tick counter, h_cnt, v_cnt = 0; pix_tick = 0; frame_start = 0; hsync = vsync = 1; valid = 0; colours = 0; all pipeline stages cleared to the inactive state.
REQ-030 Reset mid-frame SHALL abort the frame; the first pix_tick after release SHALL come PCLK_DIV clks after release and SHALL produce h_cnt=1, v_cnt=0; no sync pulse SHALL be generated from stale pipeline data.

Configuration
REQ-031 Macro VGA_COMPOSITOR_TESTPAT_EN SHALL compile in an input testpat_sel (1 bit); when it is 1, the composited colour is replaced by 8 vertical colour bars of width H_ACTIVE/8 (black, red, green, blue, yellow, cyan, magenta, white), with the same latency and blanking as normal pixels.
REQ-032 Without VGA_COMPOSITOR_TESTPAT_EN, the testpat_sel port and the bar logic SHALL be absent.

Verification
REQ-033 Defaults, 2 full frames -> pix_tick every 4 clk; 800 ticks per line; hsync low for h_cnt 656..751; vsync low for lines 490..491; frame_start every 420000 ticks.
REQ-034 N_LAYERS=3, layer0=12'hF0F, layer1=12'h0F0, layer2=12'hF00, all enabled -> active output 12'h0F0; clear layer_en[1] -> 12'hF00; all disabled -> BG_COLOR.
REQ-035 SRC_LAT=2, layer_pixel driven as {h_cnt[3:0],8'h00} -> output at active pixel h equals {h[3:0],8'h00}, aligned with valid; first valid pixel at output is h=0.
REQ-036 Assert force_black for 10 pixels mid-line -> colours 0 for exactly those clks; hsync/vsync timing unchanged.
REQ-037 Assert rst at h_cnt=300, v_cnt=200 for 3 clk -> all outputs at reset values immediately; after release, h_cnt=1, v_cnt=0 at the first pix_tick, which comes 4 clk after release.
REQ-038 With VGA_COMPOSITOR_TESTPAT_EN defined, testpat_sel=1 -> h 0..79 = 12'h000, h 80..159 = 12'hF00, h 560..639 = 12'hFFF.
